uart_rx_monitor: RTL and testbench

- FPGA-side UART receiver that decodes the serial stream driven by the SoC UART TX pin (8N1, LSB first) into bytes.
- Used by the board wrapper and by on-FPGA self-check harnesses to capture SoC console output without an external host.
- Includes a 2-flop input synchroniser, a bit-timing FSM, a small output FIFO with valid/ready handshake, and framing and overflow reporting.

---
 rtl/uart_rx_monitor.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
//   Receives an 8N1, LSB-first UART stream from the SoC TX pin. Each good byte
//   is placed in a small output FIFO that the consumer drains with a
//   valid/ready handshake.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous, active-low reset
//   rx_i           serial line, asynchronous to clk_i, idle high
//   rx_enable_i    receiver enable; dropping it aborts any frame in progress
//   clear_i        synchronous pulse: flush the FIFO and clear overflow_o
//   data_o         head-of-FIFO byte (0 while the FIFO is empty)
//   valid_o        data_o holds a byte
//   ready_i        consumer takes data_o on a cycle where valid_o && ready_i
//   frame_err_o    one-cycle pulse when a stop bit is sampled low
//   overflow_o     sticky: a received byte was dropped because the FIFO was full
//   busy_o         receiver FSM is not idle
//   fifo_level_o   number of bytes held in the FIFO (0..FifoDepth)
//
// Handshake: a byte moves to the consumer on every rising clock edge where
// valid_o and ready_i are both high. valid_o never depends combinationally on
// ready_i, and data_o stays stable while valid_o is high and ready_i is low.

module uart_rx_monitor #(
  parameter int unsigned ClkFreqHz = 50000000,
  parameter int unsigned BaudRate  = 115200,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           rx_i,
  input  logic                           rx_enable_i,
  input  logic                           clear_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           frame_err_o,
  output logic                           overflow_o,
  output logic                           busy_o,
  output logic [$clog2(FifoDepth):0]     fifo_level_o
);

  localparam int unsigned ClksPerBit = ClkFreqHz / BaudRate;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned PtrW       = $clog2(FifoDepth);
  localparam int unsigned LvlW       = PtrW + 1;

  localparam logic [CntW-1:0] HalfLast  = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast   = CntW'(ClksPerBit - 1);
  localparam logic [LvlW-1:0] LevelFull = LvlW'(FifoDepth);

  // Reject parameter sets the timing logic or the FIFO cannot support.
  if (ClksPerBit < 4) begin : g_bad_clks_per_bit
    $error("uart_rx_monitor: ClkFreqHz/BaudRate must be at least 4");
  end
  if ((FifoDepth < 2) || (FifoDepth > 16) ||
      ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_fifo_depth
    $error("uart_rx_monitor: FifoDepth must be a power of two in 2..16");
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both flops reset high so that reset does not look like
  // a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-timing FSM
  //   The cycle in IDLE that sees rx_s low is t0. START samples at t0+H, every
  //   DATA bit and the STOP bit are sampled one bit period after the previous
  //   sample. cnt_q restarts at 0 on the cycle after each sample.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_enable_i && !rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          // Shift in at the MSB so the first bit ends up in bit 0.
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        // Hold off start detection until a break or a stuck-low line releases.
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disabling the receiver abandons the frame silently.
    if (!rx_enable_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      push_d  = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  //   push_q is high for one cycle after a good stop sample, and shift_q still
  //   holds the received byte in that cycle (it only changes in DATA).
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] count_q, count_d;
  logic            valid_q;
  logic            ovf_q, ovf_d;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic            push_drop;

  assign pop       = valid_q && ready_i;
  assign full      = (count_q == LevelFull);
  // A full FIFO still takes the byte if a slot frees up in the same cycle.
  assign push_ok   = push_q && (!full || pop);
  assign push_drop = push_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (clear_i) begin
      // Flush wins over a push arriving in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push_drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible while valid_q is high.
  always_ff @(posedge clk_i) begin
    if (!clear_i && push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign data_o       = valid_q ? mem_q[rd_ptr_q] : 8'h00;
  assign valid_o      = valid_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign fifo_level_o = count_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor
//   Directed bench for uart_rx_monitor at C = 10 clocks per bit (H = 5).
//   Cycle numbers in comments count falling edges after the falling edge on
//   which the start bit is driven.

module tb_uart_rx_monitor;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned C      = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       rx_en = 1'b1;
  logic       clr   = 1'b0;
  logic       rdy   = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovf;
  logic       busy;
  logic [2:0] level;

  always #5 clk = ~clk;

  uart_rx_monitor #(
    .ClkFreqHz (CLK_HZ),
    .BaudRate  (BAUD),
    .FifoDepth (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_i         (rx),
    .rx_enable_i  (rx_en),
    .clear_i      (clr),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (rdy),
    .frame_err_o  (ferr),
    .overflow_o   (ovf),
    .busy_o       (busy),
    .fifo_level_o (level)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         ferr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Records every handshake and every frame-error cycle, sampled between edges.
  always @(negedge clk) begin
    #2;
    if (rst_n && valid && rdy) got_q.push_back(data);
    if (rst_n && ferr) ferr_cnt++;
  end

  task automatic drain_check(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called on a falling edge, return on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  task automatic pop_n(input int n);
    rdy = 1'b1;
    repeat (n) @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_data"},  data,  0);
    check({tag, "_ovf"},   ovf,   0);
    check({tag, "_ferr"},  ferr,  0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("after_reset");

    // 0xA5: valid first seen at edge 99 (t0 = edge 2, H+9C+2 = 97), one cycle.
    rdy = 1'b1;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (50) @(negedge clk);
        check("a5_busy_mid", busy, 1);
        repeat (48) @(negedge clk);
        check("a5_valid_early", valid, 0);
        check("a5_busy_after_stop", busy, 0);
        @(negedge clk);
        check("a5_valid_rise", valid, 1);
        check("a5_data", data, 8'hA5);
        @(negedge clk);
        check("a5_valid_fall", valid, 0);
      end
    join
    exp_q.push_back(8'hA5);
    repeat (5) @(negedge clk);
    drain_check("a5_sb");
    check("a5_ferr", ferr_cnt, 0);

    // Two-cycle glitch: rejected at the mid start-bit sample.
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("glitch_level", level, 0);
    check("glitch_ferr", ferr_cnt, 0);
    drain_check("glitch_sb");

    // Bad stop bit on 0x3C, then 0x55 once the line is high again.
    rdy = 1'b0;
    send_byte(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_pulses", ferr_cnt, 1);
    check("ferr_level", level, 0);
    check("ferr_busy", busy, 0);
    send_byte(8'h55, 1'b1);
    repeat (5) @(negedge clk);
    check("after_ferr_level", level, 1);
    check("after_ferr_valid", valid, 1);
    check("after_ferr_data", data, 8'h55);
    pop_n(1);
    exp_q.push_back(8'h55);
    repeat (2) @(negedge clk);
    drain_check("after_ferr_sb");

    // Five back-to-back bytes into a 4-deep FIFO with the consumer stalled.
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
    repeat (10) @(negedge clk);
    check("ovf_level", level, 4);
    check("ovf_flag", ovf, 1);
    check("ovf_head", data, 8'h01);
    pop_n(4);
    for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
    repeat (2) @(negedge clk);
    drain_check("ovf_sb");
    check("ovf_empty", level, 0);
    check("ovf_sticky", ovf, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clear_ovf", ovf, 0);
    check("clear_valid", valid, 0);

    // Full FIFO, pop on the exact cycle of the push (push lands at edge 99).
    for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 1'b1);
    repeat (5) @(negedge clk);
    check("full_level", level, 4);
    fork
      send_byte(8'h14, 1'b1);
      begin
        repeat (98) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("simul_level", level, 4);
    check("simul_ovf", ovf, 0);
    pop_n(4);
    for (int b = 0; b < 5; b++) exp_q.push_back(8'h10 + 8'(b));
    repeat (2) @(negedge clk);
    drain_check("simul_sb");

    // Disable after data bit 3 of 0xFF (sampled at edge 47).
    rdy = 1'b1;
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (50) @(negedge clk);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", busy, 0);
        repeat (8) @(negedge clk);
        rx_en = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    check("abort_level", level, 0);
    check("abort_ferr", ferr_cnt, 1);
    drain_check("abort_sb");
    send_byte(8'h12, 1'b1);
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h12);
    drain_check("post_abort_sb");

    // Asynchronous reset mid-frame with a byte waiting in the FIFO.
    rdy = 1'b0;
    send_byte(8'h66, 1'b1);
    repeat (5) @(negedge clk);
    check("prerst_level", level, 1);
    fork
      send_byte(8'h7E, 1'b1);
      begin
        repeat (40) @(negedge clk);
        check("prerst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midframe_rst");
      end
    join
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_level", level, 0);
    check("postrst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
